// File: rtl/ram_pll_pkg.sv
// Shared types and default timing constants for the RAM-clock PLL supervisor.
// The cycle defaults assume the 27 MHz reference clock.
package ram_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 27;     // 1 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 27000;  // 1 ms
  localparam int DEF_LOCK_STABLE_CYCLES  = 2700;   // 100 us
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_CNT_W               = 16;

  localparam logic [7:0] LOST_CNT_MAX = 8'd255;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer that brings the asynchronous PLL LOCK into the clkin domain.
// The output is held low while rst_n is low.
module pll_lock_sync (
  input  logic clkin,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ram_pll_supervisor.sv
// Sequences the RAM-clock PLL: reset pulse, lock wait with retries, and lock qualification.
// The PSRAM reset is released only after qualification. All outputs are registered from the next state.
module ram_pll_supervisor
  import ram_pll_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          pll_lock,
  input  logic          restart,
  output logic          pll_reset,
  output logic          ram_rst_n,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    lock_lost_cnt
);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRIES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [RW-1:0]    retry_reg, retry_next;
  logic [7:0]       lost_reg, lost_next;
  logic             pll_reset_reg, pll_reset_next;
  logic             ram_rst_n_reg, ram_rst_n_next;
  logic             fault_reg, fault_next;
  logic             lock_s;

  pll_lock_sync u_lock_sync (
    .clkin (clkin),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_reg     <= RESET_PLL;
      count_reg     <= '0;
      retry_reg     <= '0;
      lost_reg      <= '0;
      pll_reset_reg <= 1'b1;
      ram_rst_n_reg <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      retry_reg     <= retry_next;
      lost_reg      <= lost_next;
      pll_reset_reg <= pll_reset_next;
      ram_rst_n_reg <= ram_rst_n_next;
      fault_reg     <= fault_next;
    end
  end

  // restart is evaluated first so it overrides any same-cycle lock or timeout event
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    retry_next = retry_reg;
    lost_next  = lost_reg;
    if (restart) begin
      state_next = RESET_PLL;
      count_next = '0;
      retry_next = '0;
    end else begin
      unique case (state_reg)
        RESET_PLL: begin
          if (count_reg == PULSE_LAST) begin
            state_next = WAIT_LOCK;
            count_next = '0;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
            count_next = '0;
          end else if (count_reg == TIMEOUT_LAST) begin
            count_next = '0;
            if (retry_reg == RETRY_LIMIT) begin
              state_next = FAULT;
            end else begin
              state_next = RESET_PLL;
              retry_next = retry_reg + RW'(1);
            end
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            count_next = '0;
          end else if (count_reg == STABLE_LAST) begin
            state_next = RUN;
            count_next = '0;
            retry_next = '0;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_next = RESET_PLL;
            count_next = '0;
            if (lost_reg != LOST_CNT_MAX) begin
              lost_next = lost_reg + 8'd1;
            end
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = RESET_PLL;
          count_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    pll_reset_next = (state_next == RESET_PLL) || (state_next == FAULT);
    ram_rst_n_next = (state_next == RUN);
    fault_next     = (state_next == FAULT);
  end

  assign pll_reset     = pll_reset_reg;
  assign ram_rst_n     = ram_rst_n_reg;
  assign ready         = ram_rst_n_reg;
  assign fault         = fault_reg;
  assign retry_cnt     = retry_reg;
  assign lock_lost_cnt = lost_reg;

endmodule
